// File: rtl/fb_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fb_scanout                                                   |
// | Description : Frame-buffer scanout with SRAM prefetch, palette lookup,     |
// |               pixel/line replication and blitter handshake.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fb_scanout #(
    parameter int          BPP       = 4,
    parameter int          H_PIX     = 320,
    parameter int          V_LINES   = 240,
    parameter int          SCALE_X   = 2,
    parameter int          SCALE_Y   = 2,
    parameter logic [19:0] BUF0_BASE = 20'h00000,
    parameter logic [19:0] BUF1_BASE = 20'h10000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           frame_start,
    input  logic           line_start,
    input  logic           pix_req,
    input  logic           buf_sel,
    input  logic           enable,
    input  logic           ackBack,
    output logic           acknowledge,
    output logic           inControl,
    output logic           blitterStart,
    input  logic           pal_we,
    input  logic [BPP-1:0] pal_addr,
    input  logic [23:0]    pal_data,
    input  logic [15:0]    SRAM_DQ,
    output logic [19:0]    SRAM_ADDR,
    output logic           SRAM_CE_N,
    output logic           SRAM_OE_N,
    output logic           SRAM_WE_N,
    output logic           SRAM_UB_N,
    output logic           SRAM_LB_N,
    output logic [7:0]     red,
    output logic [7:0]     green,
    output logic [7:0]     blue,
    output logic           underflow
);

    localparam int         WPL       = H_PIX * BPP / 16;
    localparam int         PIX_LINE  = H_PIX * SCALE_X;
    localparam int         PCW       = (PIX_LINE > 1) ? $clog2(PIX_LINE) : 1;
    localparam int         FCW       = $clog2(WPL + 1);
    localparam int         LCW       = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam int         XW        = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
    localparam int         YW        = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
    localparam logic [3:0] FIRST_OFS = 4'(16 - BPP);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACK   = 3'd1,
        S_ARM   = 3'd2,
        S_SCAN  = 3'd3,
        S_HWAIT = 3'd4,
        S_TERM  = 3'd5
    } state_t;

    state_t           r_state, w_next;
    logic [19:0]      r_line_addr;
    logic [FCW-1:0]   r_fetch_cnt;
    logic             r_inflight;
    logic [15:0]      r_fifo [0:1];
    logic             r_wr_ptr, r_rd_ptr;
    logic [1:0]       r_count;
    logic [3:0]       r_bit_ofs;
    logic [XW-1:0]    r_rep_x;
    logic [PCW-1:0]   r_pix_cnt;
    logic [YW-1:0]    r_rep_y;
    logic [LCW-1:0]   r_line_cnt;
    logic             r_frame_done;
    logic [23:0]      r_pal [0:(2**BPP)-1];
    logic [23:0]      r_rgb;
    logic             r_underflow;

    logic             w_active, w_resync, w_accept, w_svc, w_empty;
    logic             w_line_end, w_last_line, w_issue, w_pop, w_x_last;
    logic [15:0]      w_head;
    logic [BPP-1:0]   w_idx;

    assign w_active    = (r_state == S_SCAN) || (r_state == S_HWAIT);
    assign w_resync    = frame_start && w_active;
    assign w_accept    = w_resync || (frame_start && (r_state == S_ARM));
    assign w_svc       = pix_req && (r_state == S_SCAN);
    assign w_empty     = (r_count == 2'd0);
    assign w_line_end  = (r_state == S_SCAN) && !w_resync &&
                         (line_start || (w_svc && (r_pix_cnt == PCW'(PIX_LINE - 1))));
    assign w_last_line = (r_line_cnt == LCW'(V_LINES - 1)) && (r_rep_y == YW'(SCALE_Y - 1));
    // In-flight reads reserve a FIFO slot so a capture can never overflow it.
    assign w_issue     = w_active && !r_frame_done && !w_resync && !w_line_end &&
                         ((3'(r_count) + 3'(r_inflight)) < 3'd2) &&
                         (r_fetch_cnt < FCW'(WPL));
    assign w_x_last    = (r_rep_x == XW'(SCALE_X - 1));
    assign w_pop       = w_svc && !w_empty && w_x_last && (r_bit_ofs == 4'd0);
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_idx       = BPP'(w_head >> r_bit_ofs);

    assign SRAM_ADDR   = inControl ? (r_line_addr + 20'(r_fetch_cnt)) : 20'h00000;
    assign SRAM_CE_N   = 1'b0;
    assign SRAM_OE_N   = 1'b0;
    assign SRAM_WE_N   = 1'b1;
    assign SRAM_UB_N   = 1'b0;
    assign SRAM_LB_N   = 1'b0;
    assign red         = r_rgb[23:16];
    assign green       = r_rgb[15:8];
    assign blue        = r_rgb[7:0];
    assign underflow   = r_underflow;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        acknowledge  = 1'b0;
        inControl    = 1'b0;
        blitterStart = 1'b0;
        case (r_state)
            S_IDLE:  if (enable) w_next = S_ACK;
            S_ACK: begin
                acknowledge = 1'b1;
                inControl   = 1'b1;
                w_next      = S_ARM;
            end
            S_ARM: begin
                inControl = 1'b1;
                if (frame_start) w_next = S_SCAN;
            end
            S_SCAN: begin
                inControl = 1'b1;
                if (w_line_end) w_next = S_HWAIT;
            end
            S_HWAIT: begin
                inControl = 1'b1;
                if (!w_resync) begin
                    if (r_frame_done)    w_next = S_TERM;
                    else if (line_start) w_next = S_SCAN;
                end
            end
            S_TERM: begin
                blitterStart = 1'b1;
                if (ackBack) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_line_addr  <= 20'h00000;
            r_fetch_cnt  <= '0;
            r_inflight   <= 1'b0;
            r_fifo[0]    <= 16'h0000;
            r_fifo[1]    <= 16'h0000;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= 2'd0;
            r_bit_ofs    <= FIRST_OFS;
            r_rep_x      <= '0;
            r_pix_cnt    <= '0;
            r_rep_y      <= '0;
            r_line_cnt   <= '0;
            r_frame_done <= 1'b0;
            r_rgb        <= 24'h000000;
            r_underflow  <= 1'b0;
            for (int i = 0; i < 2**BPP; i++) r_pal[i] <= 24'h000000;
        end else begin
            // Palette read uses the pre-write value on a same-entry collision.
            r_rgb <= (w_svc && !w_empty) ? r_pal[w_idx] : 24'h000000;
            if (w_svc && w_empty) r_underflow <= 1'b1;
            if (pal_we) r_pal[pal_addr] <= pal_data;
            if (r_inflight) r_fifo[r_wr_ptr] <= SRAM_DQ;
            r_inflight <= w_issue;
            if (w_issue) r_fetch_cnt <= r_fetch_cnt + 1'b1;

            if (w_accept || w_line_end) begin
                r_fetch_cnt <= '0;
                r_inflight  <= 1'b0;
                r_wr_ptr    <= 1'b0;
                r_rd_ptr    <= 1'b0;
                r_count     <= 2'd0;
                r_bit_ofs   <= FIRST_OFS;
                r_rep_x     <= '0;
                r_pix_cnt   <= '0;
            end

            if (w_accept) begin
                r_line_addr  <= buf_sel ? BUF1_BASE : BUF0_BASE;
                r_rep_y      <= '0;
                r_line_cnt   <= '0;
                r_frame_done <= 1'b0;
            end else if (w_line_end) begin
                if (r_rep_y == YW'(SCALE_Y - 1)) begin
                    r_rep_y     <= '0;
                    r_line_addr <= r_line_addr + 20'(WPL);
                    r_line_cnt  <= r_line_cnt + 1'b1;
                end else begin
                    r_rep_y <= r_rep_y + 1'b1;
                end
                if (w_last_line) r_frame_done <= 1'b1;
            end else begin
                if (r_inflight) r_wr_ptr <= ~r_wr_ptr;
                if (w_pop)      r_rd_ptr <= ~r_rd_ptr;
                case ({r_inflight, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
                // Counters advance even on underflow to keep the line length fixed.
                if (w_svc) begin
                    r_pix_cnt <= r_pix_cnt + 1'b1;
                    if (w_x_last) begin
                        r_rep_x   <= '0;
                        r_bit_ofs <= (r_bit_ofs == 4'd0) ? FIRST_OFS : (r_bit_ofs - 4'(BPP));
                    end else begin
                        r_rep_x <= r_rep_x + 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fb_scanout                                                |
// | Description : Directed self-checking bench for fb_scanout (16x2 source).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fb_scanout;

    logic        clk, reset, frame_start, line_start, pix_req, buf_sel;
    logic        enable, ackBack, acknowledge, inControl, blitterStart;
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [23:0] pal_data;
    logic [15:0] SRAM_DQ;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
    logic [7:0]  red, green, blue;
    logic        underflow;
    logic [19:0] sram_addr_q;
    int          checks = 0;
    int          errors = 0;

    fb_scanout #(
        .BPP(4), .H_PIX(16), .V_LINES(2), .SCALE_X(2), .SCALE_Y(2),
        .BUF0_BASE(20'h00000), .BUF1_BASE(20'h10000)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
        .pix_req(pix_req), .buf_sel(buf_sel), .enable(enable), .ackBack(ackBack),
        .acknowledge(acknowledge), .inControl(inControl), .blitterStart(blitterStart),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
        .red(red), .green(green), .blue(blue), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: data for the address seen at an edge appears in the following cycle.
    function automatic logic [15:0] word_at(input logic [19:0] a);
        if (a == 20'h00000) return 16'h1200;
        if (a == 20'h10000) return 16'h2100;
        return 16'h0000;
    endfunction
    always @(posedge clk) sram_addr_q <= SRAM_ADDR;
    assign SRAM_DQ = word_at(sram_addr_q);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pix(input int n);
        pix_req = 1'b1;
        repeat (n) tick();
        pix_req = 1'b0;
    endtask

    task automatic new_line();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        idle(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({acknowledge, inControl, blitterStart} !== 3'b000) begin errors++;
            $display("FAIL reset_handshake: got %b expected 000", {acknowledge, inControl, blitterStart}); end
        checks++; if (underflow !== 1'b0) begin errors++;
            $display("FAIL reset_underflow: got %b expected 0", underflow); end
        checks++; if ({red, green, blue} !== 24'h0 || SRAM_ADDR !== 20'h0) begin errors++;
            $display("FAIL reset_outputs: got rgb %h addr %h expected 0 0", {red, green, blue}, SRAM_ADDR); end
        checks++; if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} !== 5'b00100) begin errors++;
            $display("FAIL sram_ctrl: got %b expected 00100", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}); end
    endtask

    task automatic test_handshake();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        checks++; if ({acknowledge, inControl} !== 2'b11) begin errors++;
            $display("FAIL ack_state: got %b expected 11", {acknowledge, inControl}); end
        pix_req = 1'b1;
        tick();
        pix_req = 1'b0;
        checks++; if ({acknowledge, inControl} !== 2'b01) begin errors++;
            $display("FAIL arm_state: got %b expected 01", {acknowledge, inControl}); end
        tick();
        checks++; if ({red, green, blue} !== 24'h0 || underflow !== 1'b0) begin errors++;
            $display("FAIL pix_req_in_arm: got rgb %h uf %b expected 0 0", {red, green, blue}, underflow); end
    endtask

    task automatic test_unpack();
        logic [23:0] exp_rgb [0:3];
        exp_rgb[0] = 24'h0080FF; exp_rgb[1] = 24'h0080FF;
        exp_rgb[2] = 24'h0000FF; exp_rgb[3] = 24'h0000FF;
        pal_we = 1'b1; pal_addr = 4'd1; pal_data = 24'h0080FF; tick();
        pal_addr = 4'd2; pal_data = 24'h0000FF; tick();
        pal_we = 1'b0;
        buf_sel = 1'b0; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++; if (SRAM_ADDR !== 20'h00000 || inControl !== 1'b1) begin errors++;
            $display("FAIL first_addr_buf0: got %h ic %b expected 00000 1", SRAM_ADDR, inControl); end
        idle(2);
        for (int i = 0; i < 4; i++) begin
            pix(1);
            checks++; if ({red, green, blue} !== exp_rgb[i]) begin errors++;
                $display("FAIL unpack_pixel%0d: got %h expected %h", i, {red, green, blue}, exp_rgb[i]); end
        end
        pix(4);
        tick();
        checks++; if ({red, green, blue} !== 24'h0) begin errors++;
            $display("FAIL idle_black: got %h expected 000000", {red, green, blue}); end
        pix(24);
        checks++; if (SRAM_ADDR !== 20'h00000 || inControl !== 1'b1) begin errors++;
            $display("FAIL line0_repeat_addr: got %h expected 00000", SRAM_ADDR); end
    endtask

    task automatic test_line_repeat();
        new_line();
        pix(32);
        checks++; if (SRAM_ADDR !== 20'h00004) begin errors++;
            $display("FAIL line2_addr: got %h expected 00004", SRAM_ADDR); end
        new_line();
        pix(32);
        new_line();
        pix(32);
        checks++; if (SRAM_ADDR !== 20'h00008 || inControl !== 1'b1) begin errors++;
            $display("FAIL frame_end_hwait: got %h ic %b expected 00008 1", SRAM_ADDR, inControl); end
        tick();
        checks++; if ({blitterStart, inControl, SRAM_ADDR} !== {2'b10, 20'h0}) begin errors++;
            $display("FAIL term_state: got bs %b ic %b addr %h expected 1 0 0", blitterStart, inControl, SRAM_ADDR); end
        ackBack = 1'b1;
        tick();
        ackBack = 1'b0;
        checks++; if ({blitterStart, inControl, acknowledge} !== 3'b000) begin errors++;
            $display("FAIL ackback_idle: got %b expected 000", {blitterStart, inControl, acknowledge}); end
        checks++; if (underflow !== 1'b0) begin errors++;
            $display("FAIL frame_no_underflow: got %b expected 0", underflow); end
    endtask

    task automatic test_double_buffer();
        enable = 1'b1; tick(); enable = 1'b0; tick();
        buf_sel = 1'b1; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; buf_sel = 1'b0;
        checks++; if (SRAM_ADDR !== 20'h10000) begin errors++;
            $display("FAIL first_addr_buf1: got %h expected 10000", SRAM_ADDR); end
        idle(2);
        pix(1);
        checks++; if ({red, green, blue} !== 24'h0000FF) begin errors++;
            $display("FAIL buf1_pixel: got %h expected 0000FF", {red, green, blue}); end
        pix(31);
        buf_sel = 1'b1;
        new_line();
        buf_sel = 1'b0;
        pix(32);
        checks++; if (SRAM_ADDR !== 20'h10004) begin errors++;
            $display("FAIL buf_sel_ignored: got %h expected 10004", SRAM_ADDR); end
        // Resync while waiting for the next line: stays in HWAIT and keeps prefetching.
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++; if (SRAM_ADDR !== 20'h00000 || inControl !== 1'b1) begin errors++;
            $display("FAIL resync_addr: got %h expected 00000", SRAM_ADDR); end
        tick();
        checks++; if (SRAM_ADDR !== 20'h00001) begin errors++;
            $display("FAIL resync_stays_hwait: got %h expected 00001", SRAM_ADDR); end
    endtask

    task automatic test_flush();
        new_line();
        pix(3);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        checks++; if (SRAM_ADDR !== 20'h00000 || inControl !== 1'b1) begin errors++;
            $display("FAIL flush_addr: got %h expected 00000", SRAM_ADDR); end
        new_line();
        pix(1);
        checks++; if ({red, green, blue} !== 24'h0080FF) begin errors++;
            $display("FAIL flush_first_pixel: got %h expected 0080FF", {red, green, blue}); end
        pix(31);
        checks++; if (SRAM_ADDR !== 20'h00004) begin errors++;
            $display("FAIL flush_counts_line: got %h expected 00004", SRAM_ADDR); end
    endtask

    task automatic test_underflow();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        pix(1);
        checks++; if ({red, green, blue} !== 24'h0 || underflow !== 1'b1) begin errors++;
            $display("FAIL underflow_set: got rgb %h uf %b expected 000000 1", {red, green, blue}, underflow); end
        idle(3);
        checks++; if (underflow !== 1'b1) begin errors++;
            $display("FAIL underflow_sticky: got %b expected 1", underflow); end
    endtask

    task automatic test_reset_mid_scan();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({inControl, underflow, SRAM_ADDR} !== 22'h0) begin errors++;
            $display("FAIL mid_reset: got ic %b uf %b addr %h expected 0 0 0", inControl, underflow, SRAM_ADDR); end
        enable = 1'b1;
        tick();
        enable = 1'b0;
        checks++; if (acknowledge !== 1'b1) begin errors++;
            $display("FAIL reset_to_idle: got ack %b expected 1", acknowledge); end
        tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        idle(2);
        pix(1);
        checks++; if ({red, green, blue} !== 24'h0 || underflow !== 1'b0) begin errors++;
            $display("FAIL palette_cleared: got rgb %h uf %b expected 000000 0", {red, green, blue}, underflow); end
        pix(1);
        pal_we = 1'b1; pal_addr = 4'd2; pal_data = 24'h123456;
        pix(1);
        pal_we = 1'b0;
        checks++; if ({red, green, blue} !== 24'h000000) begin errors++;
            $display("FAIL pal_collision_old: got %h expected 000000", {red, green, blue}); end
        pix(1);
        checks++; if ({red, green, blue} !== 24'h123456) begin errors++;
            $display("FAIL pal_write_new: got %h expected 123456", {red, green, blue}); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; frame_start = 1'b0; line_start = 1'b0; pix_req = 1'b0;
        buf_sel = 1'b0; enable = 1'b0; ackBack = 1'b0;
        pal_we = 1'b0; pal_addr = 4'd0; pal_data = 24'h0;
        test_reset();
        test_handshake();
        test_unpack();
        test_line_repeat();
        test_double_buffer();
        test_flush();
        test_underflow();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
